// File: rtl/binary_dilation_3x3.sv
// Streaming 3x3 binary dilation over a causal window with zero padding at line/frame borders.
// The window OR for each accepted pixel is three register stages behind the input stream.
module binary_dilation_3x3 #(
    parameter int IMG_WIDTH = 640,
    parameter int LATENCY   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pre_frame_vsync,
    input  logic pre_frame_href,
    input  logic pre_frame_clken,
    input  logic pre_img_bit,
    output logic post_frame_vsync,
    output logic post_frame_href,
    output logic post_frame_clken,
    output logic post_img_bit,
    output logic line_ovf
);

    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

    generate
        if (LATENCY != 3) begin : g_bad_latency
            $error("binary_dilation_3x3: LATENCY must be 3");
        end
    endgenerate

    logic vsync_q;
    logic href_q;
    logic vs_rise;
    logic href_fall;
    logic accept;

    logic [CW-1:0] col;
    logic [CW-1:0] col_eff;
    logic [CW-1:0] col_nxt;
    logic [1:0]    row;
    logic [1:0]    row_eff;
    logic [1:0]    row_nxt;
    logic          line_active;
    logic          line_active_nxt;
    logic          last_written;
    logic          last_eff;
    logic          last_nxt;
    logic          ovf_nxt;

    logic lb0 [IMG_WIDTH];
    logic lb1 [IMG_WIDTH];

    logic       v1;
    logic       b1;
    logic       first1;
    logic [1:0] row1;
    logic       rd0;
    logic       rd1;

    logic       v2;
    logic [2:0] win_top;
    logic [2:0] win_mid;
    logic [2:0] win_bot;
    logic       top_new;
    logic       mid_new;

    logic [2:0] ctl1;
    logic [2:0] ctl2;
    logic [2:0] ctl3;

    assign vs_rise   = pre_frame_vsync & ~vsync_q;
    assign href_fall = href_q & ~pre_frame_href;
    assign accept    = pre_frame_href & pre_frame_clken;

    // A vsync rise takes effect before a coincident pixel, making it (row 0, col 0).
    always_comb begin
        col_eff  = vs_rise ? '0 : col;
        row_eff  = vs_rise ? 2'd0 : row;
        last_eff = vs_rise ? 1'b0 : last_written;
    end

    always_comb begin
        col_nxt         = col;
        row_nxt         = row;
        line_active_nxt = line_active;
        last_nxt        = last_written;
        ovf_nxt         = line_ovf;
        if (vs_rise) begin
            col_nxt         = '0;
            row_nxt         = 2'd0;
            line_active_nxt = 1'b0;
            last_nxt        = 1'b0;
            ovf_nxt         = 1'b0;
        end else if (href_fall) begin
            col_nxt         = '0;
            line_active_nxt = 1'b0;
            last_nxt        = 1'b0;
            if (line_active && row != 2'd2) begin
                row_nxt = row + 2'd1;
            end
        end
        if (accept) begin
            line_active_nxt = 1'b1;
            if (col_eff == COL_LAST) begin
                col_nxt  = col_eff;
                last_nxt = 1'b1;
                if (last_eff) begin
                    ovf_nxt = 1'b1;
                end
            end else begin
                col_nxt = col_eff + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            col          <= '0;
            row          <= 2'd0;
            line_active  <= 1'b0;
            last_written <= 1'b0;
            line_ovf     <= 1'b0;
        end else begin
            vsync_q      <= pre_frame_vsync;
            href_q       <= pre_frame_href;
            col          <= col_nxt;
            row          <= row_nxt;
            line_active  <= line_active_nxt;
            last_written <= last_nxt;
            line_ovf     <= ovf_nxt;
        end
    end

    // Line buffers are deliberately unreset; row/column masking hides stale contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col_eff] <= pre_img_bit;
            lb1[col_eff] <= lb0[col_eff];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            b1     <= 1'b0;
            first1 <= 1'b0;
            row1   <= 2'd0;
            rd0    <= 1'b0;
            rd1    <= 1'b0;
        end else begin
            v1 <= accept;
            if (accept) begin
                b1     <= pre_img_bit;
                first1 <= (col_eff == '0);
                row1   <= row_eff;
                rd0    <= lb0[col_eff];
                rd1    <= lb1[col_eff];
            end
        end
    end

    always_comb begin
        mid_new = rd0 & (row1 != 2'd0);
        top_new = rd1 & (row1 == 2'd2);
    end

    // Window bit 0 is column c, bit 1 is c-1, bit 2 is c-2; older columns clear at line start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            win_top <= 3'b000;
            win_mid <= 3'b000;
            win_bot <= 3'b000;
        end else begin
            v2 <= v1;
            if (v1) begin
                win_top <= first1 ? {2'b00, top_new} : {win_top[1:0], top_new};
                win_mid <= first1 ? {2'b00, mid_new} : {win_mid[1:0], mid_new};
                win_bot <= first1 ? {2'b00, b1}      : {win_bot[1:0], b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl1         <= 3'b000;
            ctl2         <= 3'b000;
            ctl3         <= 3'b000;
            post_img_bit <= 1'b0;
        end else begin
            ctl1         <= {pre_frame_vsync, pre_frame_href, pre_frame_clken};
            ctl2         <= ctl1;
            ctl3         <= ctl2;
            post_img_bit <= v2 & ((|win_top) | (|win_mid) | (|win_bot));
        end
    end

    assign post_frame_vsync = ctl3[2];
    assign post_frame_href  = ctl3[1];
    assign post_frame_clken = ctl3[0];

endmodule
